// File: rtl/vend2_ctrl.sv
// Vending credit/dispense controller: accumulates money, answers vend requests, pays change coin by coin.
// Optional build macro VEND2_AUTO_CHANGE_EN pays out the remaining credit automatically after every vend.
module vend2_ctrl #(
  parameter logic [15:0] MAX_CREDIT = 16'd9999,
  parameter logic [15:0] DENOM_MASK = 16'h0426
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        money_present,
  input  logic [3:0]  money_amount,
  output logic        vend_idle,
  output logic        money_return,
  output logic [3:0]  return_amount,
  input  logic        return_complete,
  input  logic        vend_request,
  input  logic [11:0] vend_amount,
  output logic        vend_ok,
  output logic        vend_reject,
  input  logic        vend_complete,
  input  logic        vend_cancel,
  output logic        cancel_complete,
  input  logic [15:0] hopper_empty,
  output logic [15:0] total
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND_WAIT,
    S_REJECT,
    S_RET,
    S_RET_GAP,
    S_CXL_DONE
  } state_t;

  state_t      state, state_nx;
  logic [15:0] total_q, total_nx;
  logic [15:0] price_q, price_nx;
  logic [3:0]  coin_q, coin_nx;
  logic        refund_q, refund_nx;

  // Largest stocked coin value that still fits in the credit; 0 means nothing can be paid.
  function automatic logic [3:0] pick_coin(input logic [15:0] credit, input logic [15:0] empty);
    logic [3:0] best;
    best = 4'd0;
    for (int d = 0; d < 16; d++) begin
      if (DENOM_MASK[d] && !empty[d] && credit >= 16'(d)) best = 4'(d);
    end
    return best;
  endfunction

  logic [3:0]  coin_cur;
  logic [16:0] money_sum;

  assign coin_cur  = pick_coin(total_q, hopper_empty);
  assign money_sum = {1'b0, total_q} + {13'd0, money_amount};

`ifdef VEND2_AUTO_CHANGE_EN
  logic [15:0] total_after;
  logic [3:0]  coin_after;
  assign total_after = total_q - price_q;
  assign coin_after  = pick_coin(total_after, hopper_empty);
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx  = state;
    total_nx  = total_q;
    price_nx  = price_q;
    coin_nx   = coin_q;
    refund_nx = refund_q;
    case (state)
      S_IDLE: begin
        if (vend_cancel) begin
          refund_nx = 1'b1;
          coin_nx   = coin_cur;
          state_nx  = (coin_cur == 4'd0) ? S_CXL_DONE : S_RET;
        end else if (money_present) begin
          if (money_amount != 4'd0) begin
            if (money_sum <= {1'b0, MAX_CREDIT}) begin
              total_nx = money_sum[15:0];
            end else begin
              refund_nx = 1'b0;
              coin_nx   = money_amount;
              state_nx  = S_RET;
            end
          end
        end else if (vend_request) begin
          price_nx = {4'd0, vend_amount};
          if (vend_amount != 12'd0 && {4'd0, vend_amount} <= total_q) state_nx = S_VEND_WAIT;
          else                                                        state_nx = S_REJECT;
        end
      end
      S_VEND_WAIT: begin
        if (vend_cancel) begin
          refund_nx = 1'b1;
          coin_nx   = coin_cur;
          state_nx  = (coin_cur == 4'd0) ? S_CXL_DONE : S_RET;
        end else if (vend_complete) begin
          total_nx = total_q - price_q;
`ifdef VEND2_AUTO_CHANGE_EN
          refund_nx = 1'b1;
          coin_nx   = coin_after;
          if (total_after == 16'd0)    state_nx = S_IDLE;
          else if (coin_after == 4'd0) state_nx = S_CXL_DONE;
          else                         state_nx = S_RET;
`else
          state_nx = S_IDLE;
`endif
        end
      end
      S_REJECT: state_nx = S_IDLE;
      S_RET: begin
        if (return_complete) begin
          if (refund_q) begin
            total_nx = total_q - {12'd0, coin_q};
            state_nx = S_RET_GAP;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_RET_GAP: begin
        // total already reflects the coin just paid, so the choice uses the remaining credit.
        coin_nx  = coin_cur;
        state_nx = (coin_cur == 4'd0) ? S_CXL_DONE : S_RET;
      end
      S_CXL_DONE: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      total_q  <= 16'd0;
      price_q  <= 16'd0;
      coin_q   <= 4'd0;
      refund_q <= 1'b0;
    end else begin
      state    <= state_nx;
      total_q  <= total_nx;
      price_q  <= price_nx;
      coin_q   <= coin_nx;
      refund_q <= refund_nx;
    end
  end

  assign vend_idle       = (state == S_IDLE);
  assign money_return    = (state == S_RET);
  assign return_amount   = (state == S_RET) ? coin_q : 4'd0;
  assign vend_ok         = (state == S_VEND_WAIT);
  assign vend_reject     = (state == S_REJECT);
  assign cancel_complete = (state == S_CXL_DONE);
  assign total           = total_q;

endmodule
